// File: rtl/crc_pkg.sv
// Shared CRC definitions: width-generic serial fold, bit reversal and catalogue presets.
// Latency: n/a (package of constants and pure functions).
// Backpressure: n/a.
package crc_pkg;

    // Widest CRC register and widest input beat the helper functions support.
    localparam int CRC_MAX  = 64;
    localparam int DATA_MAX = 64;

    // One catalogue entry; all fields are right-aligned in 64 bits.
    typedef struct packed {
        logic [63:0] poly;
        logic [63:0] init;
        logic [63:0] xorout;
        logic        refin;
        logic        refout;
        logic [63:0] residue;
    } crc_preset_t;

    localparam crc_preset_t CRC64_WE = '{
        poly:    64'h42F0_E1EB_A9EA_3693,
        init:    64'hFFFF_FFFF_FFFF_FFFF,
        xorout:  64'hFFFF_FFFF_FFFF_FFFF,
        refin:   1'b0,
        refout:  1'b0,
        residue: 64'hFCAC_BEBD_5931_A992
    };

    localparam crc_preset_t CRC64_ECMA182 = '{
        poly:    64'h42F0_E1EB_A9EA_3693,
        init:    64'h0,
        xorout:  64'h0,
        refin:   1'b0,
        refout:  1'b0,
        residue: 64'h0
    };

    localparam crc_preset_t CRC32_ISO_HDLC = '{
        poly:    64'h0000_0000_04C1_1DB7,
        init:    64'h0000_0000_FFFF_FFFF,
        xorout:  64'h0000_0000_FFFF_FFFF,
        refin:   1'b1,
        refout:  1'b1,
        residue: 64'h0000_0000_DEBB_20E3
    };

    // Apply data_w serial LFSR steps to a crc_w-bit register. Bits above
    // crc_w in the result are always zero. With refl_in the beat is
    // consumed from bit 0 upward, otherwise from bit data_w-1 downward.
    function automatic logic [CRC_MAX-1:0] crc_step(
        input logic [CRC_MAX-1:0]  crc,
        input logic [DATA_MAX-1:0] data,
        input logic [CRC_MAX-1:0]  poly,
        input int                  crc_w,
        input int                  data_w,
        input logic                refl_in
    );
        logic [CRC_MAX-1:0] c;
        logic [CRC_MAX-1:0] mask;
        logic               d;
        logic               fb;
        mask = (crc_w >= CRC_MAX) ? '1 : ((64'd1 << crc_w) - 64'd1);
        c    = crc & mask;
        for (int i = 0; i < DATA_MAX; i++) begin
            if (i < data_w) begin
                d  = refl_in ? data[i] : data[data_w - 1 - i];
                fb = c[crc_w - 1] ^ d;
                c  = ((c << 1) ^ (fb ? poly : '0)) & mask;
            end
        end
        return c;
    endfunction

    // Reverse the low w bits of v; bits above w come back zero.
    function automatic logic [CRC_MAX-1:0] bit_rev(
        input logic [CRC_MAX-1:0] v,
        input int                 w
    );
        logic [CRC_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < CRC_MAX; i++) begin
            if (i < w) begin
                r[i] = v[w - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_engine_if.sv
// Beat input stream plus result output stream of the CRC engine.
// Latency: n/a (wiring only).
// Backpressure: in_rdy throttles beats, crc_rdy drains the result register.
interface crc_engine_if
    import crc_pkg::*;
#(
    parameter int CRC_W  = 64,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    // Input beat stream
    logic              in_vld;
    logic              in_rdy;
    logic [DATA_W-1:0] in_dat;
    logic              in_last;

    // Per-frame result stream
    logic              crc_vld;
    logic              crc_rdy;
    logic [CRC_W-1:0]  crc_dat;
    logic              crc_ok;
    logic [CNT_W-1:0]  beat_cnt;

    // The engine side
    modport slave (
        input  in_vld, in_dat, in_last, crc_rdy,
        output in_rdy, crc_vld, crc_dat, crc_ok, beat_cnt
    );

    // The framer / link-layer side
    modport master (
        output in_vld, in_dat, in_last, crc_rdy,
        input  in_rdy, crc_vld, crc_dat, crc_ok, beat_cnt
    );
endinterface

// File: rtl/crc_pkt_fold.sv
// Folds one DATA_W-bit beat into a CRC_W-bit register, fully unrolled.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module crc_pkt_fold
    import crc_pkg::*;
#(
    parameter int          CRC_W      = 64,
    parameter int          DATA_W     = 8,
    parameter logic [63:0] POLY       = CRC64_WE.poly,
    parameter bit          REFLECT_IN = 1'b0
) (
    input  logic [CRC_W-1:0]  i_crc,
    input  logic [DATA_W-1:0] i_dat,
    output logic [CRC_W-1:0]  o_crc
);

    // DATA_W serial steps collapse into one XOR network once the
    // widths and polynomial are fixed at elaboration.
    always_comb begin
        o_crc = CRC_W'(crc_step(64'(i_crc), 64'(i_dat), POLY, CRC_W, DATA_W, REFLECT_IN));
    end

endmodule

// File: rtl/crc_engine.sv
// Parallel CRC generator/checker: one beat per cycle, per-frame result register.
// Latency: result valid the cycle after the last beat is accepted.
// Backpressure: an unconsumed result (crc_vld && !crc_rdy) or a soft clear drops in_rdy.
module crc_engine
    import crc_pkg::*;
#(
    parameter int          CRC_W       = 64,
    parameter int          DATA_W      = 8,
    parameter logic [63:0] POLY        = CRC64_WE.poly,
    parameter logic [63:0] INIT        = CRC64_WE.init,
    parameter logic [63:0] XOR_OUT     = CRC64_WE.xorout,
    parameter bit          REFLECT_IN  = 1'b0,
    parameter bit          REFLECT_OUT = 1'b0,
    parameter logic [63:0] RESIDUE     = CRC64_WE.residue,
    parameter int          CNT_W       = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    crc_engine_if.slave bus
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    localparam logic [CRC_W-1:0] L_INIT = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] L_XOR  = XOR_OUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] L_RES  = RESIDUE[CRC_W-1:0];

    // Frame state
    logic [0:0]       r_state;
    logic [CRC_W-1:0] r_crc;
    logic [CNT_W-1:0] r_cnt;

    // Result register
    logic             r_res_vld;
    logic [CRC_W-1:0] r_res_crc;
    logic             r_res_ok;
    logic [CNT_W-1:0] r_res_cnt;

    logic             w_in_rdy;
    logic             w_acc;
    logic             w_acc_last;
    logic [CRC_W-1:0] w_cur;
    logic [CRC_W-1:0] w_next;
    logic [CRC_W-1:0] w_out;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Ready depends only on the result register, its consumer and the
    // soft clear, never on in_vld, so no combinational loop to the framer.
    assign w_in_rdy   = !i_clr && !(r_res_vld && !bus.crc_rdy);
    assign w_acc      = bus.in_vld && w_in_rdy;
    assign w_acc_last = w_acc && bus.in_last;

    // A frame always starts from INIT, even if the register was left
    // holding something else.
    assign w_cur = (r_state == S_IDLE) ? L_INIT : r_crc;

    crc_pkt_fold #(
        .CRC_W      (CRC_W),
        .DATA_W     (DATA_W),
        .POLY       (POLY),
        .REFLECT_IN (REFLECT_IN)
    ) u_fold (
        .i_crc (w_cur),
        .i_dat (bus.in_dat),
        .o_crc (w_next)
    );

    // Beat count including the beat now being accepted, stuck at all ones.
    assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    // Final presentation of the folded register.
    assign w_out = (REFLECT_OUT ? CRC_W'(bit_rev(64'(w_next), CRC_W)) : w_next) ^ L_XOR;

    // Running CRC, beat counter and IDLE/ACTIVE tracking; a last beat
    // reloads INIT on the same edge so the next frame can follow directly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_crc   <= L_INIT;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_state <= S_IDLE;
            r_crc   <= L_INIT;
            r_cnt   <= '0;
        end else if (w_acc) begin
            if (bus.in_last) begin
                r_state <= S_IDLE;
                r_crc   <= L_INIT;
                r_cnt   <= '0;
            end else begin
                r_state <= S_ACTIVE;
                r_crc   <= w_next;
                r_cnt   <= w_cnt_nxt;
            end
        end
    end

    // Result register: loads on a last beat, drains on crc_rdy. Data
    // fields hold after draining; only the valid flag drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res_vld <= 1'b0;
            r_res_crc <= '0;
            r_res_ok  <= 1'b0;
            r_res_cnt <= '0;
        end else if (i_clr) begin
            r_res_vld <= 1'b0;
        end else if (w_acc_last) begin
            r_res_vld <= 1'b1;
            r_res_crc <= w_out;
            r_res_ok  <= (w_next == L_RES);
            r_res_cnt <= w_cnt_nxt;
        end else if (bus.crc_rdy) begin
            r_res_vld <= 1'b0;
        end
    end

    assign bus.in_rdy   = w_in_rdy;
    assign bus.crc_vld  = r_res_vld;
    assign bus.crc_dat  = r_res_crc;
    assign bus.crc_ok   = r_res_ok;
    assign bus.beat_cnt = r_res_cnt;

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: catalogue check values, residue, stall, clear and reset.
// Latency: expects the result one cycle after the last accepted beat.
// Backpressure: holds crc_rdy low to stall the input stream.
module tb_crc_engine;
    import crc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr;
    logic       s_vld, s_last, s_rdy;
    logic [7:0] s_dat;
    logic       e_vld, e_dat, e_last, e_rdy;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0]       len;
        logic [16:0][7:0] d;
        logic [63:0]      crc;
        logic             chk_crc;
        logic             ok;
        logic             chk_ok;
        logic [15:0]      cnt;
    } vec_t;

    vec_t vecs [4];

    crc_engine_if #(.CRC_W(64), .DATA_W(8), .CNT_W(16)) if_we  ();
    crc_engine_if #(.CRC_W(32), .DATA_W(8), .CNT_W(16)) if_c32 ();
    crc_engine_if #(.CRC_W(64), .DATA_W(8), .CNT_W(16)) if_e8  ();
    crc_engine_if #(.CRC_W(64), .DATA_W(8), .CNT_W(2))  if_sat ();
    crc_engine_if #(.CRC_W(64), .DATA_W(1), .CNT_W(16)) if_e1  ();

    // The four byte-wide engines see the same stream
    assign if_we.in_vld   = s_vld;  assign if_we.in_dat   = s_dat;
    assign if_we.in_last  = s_last; assign if_we.crc_rdy  = s_rdy;
    assign if_c32.in_vld  = s_vld;  assign if_c32.in_dat  = s_dat;
    assign if_c32.in_last = s_last; assign if_c32.crc_rdy = s_rdy;
    assign if_e8.in_vld   = s_vld;  assign if_e8.in_dat   = s_dat;
    assign if_e8.in_last  = s_last; assign if_e8.crc_rdy  = s_rdy;
    assign if_sat.in_vld  = s_vld;  assign if_sat.in_dat  = s_dat;
    assign if_sat.in_last = s_last; assign if_sat.crc_rdy = s_rdy;
    assign if_e1.in_vld   = e_vld;  assign if_e1.in_dat   = e_dat;
    assign if_e1.in_last  = e_last; assign if_e1.crc_rdy  = e_rdy;

    crc_engine u_we (.i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(if_we.slave));

    crc_engine #(
        .CRC_W(32), .DATA_W(8), .POLY(CRC32_ISO_HDLC.poly), .INIT(CRC32_ISO_HDLC.init),
        .XOR_OUT(CRC32_ISO_HDLC.xorout), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1),
        .RESIDUE(CRC32_ISO_HDLC.residue), .CNT_W(16)
    ) u_c32 (.i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(if_c32.slave));

    crc_engine #(
        .CRC_W(64), .DATA_W(8), .POLY(CRC64_ECMA182.poly), .INIT(CRC64_ECMA182.init),
        .XOR_OUT(CRC64_ECMA182.xorout), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0),
        .RESIDUE(CRC64_ECMA182.residue), .CNT_W(16)
    ) u_e8 (.i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(if_e8.slave));

    crc_engine #(.CNT_W(2)) u_sat (.i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(if_sat.slave));

    crc_engine #(
        .CRC_W(64), .DATA_W(1), .POLY(CRC64_ECMA182.poly), .INIT(CRC64_ECMA182.init),
        .XOR_OUT(CRC64_ECMA182.xorout), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0),
        .RESIDUE(CRC64_ECMA182.residue), .CNT_W(16)
    ) u_e1 (.i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(if_e1.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Present one beat on the shared stream and wait for its acceptance.
    // vld_before is crc_vld sampled just before the accepting edge.
    task automatic put_beat(input logic [7:0] d, input logic last, output logic vld_before);
        bit done;
        done       = 1'b0;
        vld_before = 1'b0;
        s_vld = 1'b1; s_dat = d; s_last = last;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            vld_before = if_we.crc_vld;
            done       = if_we.in_rdy;
            @(posedge clk); #1;
        end
        s_vld = 1'b0; s_last = 1'b0;
        if (!done) begin
            n_chk++; n_err++;
            $display("FAIL accept_timeout: beat %h still not accepted, want accepted within 40 cycles", d);
        end
    endtask

    // Send beats first..len-1 of a record and check the default engine's result.
    task automatic send_vec(input vec_t v, input int first, input string name);
        logic vb;
        for (int j = first; j < int'(v.len); j++) begin
            put_beat(v.d[j], (j == int'(v.len) - 1), vb);
            if (j == int'(v.len) - 1) chk($sformatf("%s_vld_before_last", name), 64'(vb), 64'd0);
        end
        @(negedge clk);
        chk($sformatf("%s_vld_after_last", name), 64'(if_we.crc_vld), 64'd1);
        if (v.chk_crc) chk($sformatf("%s_crc", name), if_we.crc_dat, v.crc);
        if (v.chk_ok)  chk($sformatf("%s_ok", name), 64'(if_we.crc_ok), 64'(v.ok));
        chk($sformatf("%s_cnt", name), 64'(if_we.beat_cnt), 64'(v.cnt));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] app;
        logic [7:0]  by;
        logic        vb;
        bit          done;

        rst_n = 1'b0; clr = 1'b0;
        s_vld = 1'b0; s_dat = 8'h00; s_last = 1'b0; s_rdy = 1'b1;
        e_vld = 1'b0; e_dat = 1'b0; e_last = 1'b0; e_rdy = 1'b1;

        // Vector table: "123456789", same with its CRC appended, one
        // corrupted bit, and a single-beat frame.
        for (int i = 0; i < 4; i++) vecs[i] = '0;
        for (int j = 0; j < 9; j++) vecs[0].d[j] = 8'(8'h31 + j);
        vecs[0].len = 8'd9;  vecs[0].crc = 64'h62EC59E3F1A4F00A;
        vecs[0].chk_crc = 1'b1; vecs[0].ok = 1'b0; vecs[0].chk_ok = 1'b1; vecs[0].cnt = 16'd9;
        app = 64'h62EC59E3F1A4F00A;
        vecs[1] = vecs[0];
        for (int j = 0; j < 8; j++) vecs[1].d[9 + j] = app[63 - 8*j -: 8];
        vecs[1].len = 8'd17; vecs[1].crc = 64'h03534142A6CE566D;
        vecs[1].ok = 1'b1; vecs[1].cnt = 16'd17;
        vecs[2] = vecs[1];
        vecs[2].d[0] = 8'h30; vecs[2].chk_crc = 1'b0; vecs[2].ok = 1'b0;
        vecs[3].len = 8'd1; vecs[3].d[0] = 8'hA5; vecs[3].cnt = 16'd1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_crc_vld",  64'(if_we.crc_vld),  64'd0);
        chk("rst_crc_dat",  if_we.crc_dat,       64'd0);
        chk("rst_crc_ok",   64'(if_we.crc_ok),   64'd0);
        chk("rst_beat_cnt", 64'(if_we.beat_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_rdy", 64'(if_we.in_rdy), 64'd1);
        @(posedge clk); #1;

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            send_vec(vecs[i], 0, $sformatf("tbl%0d", i));
            if (i == 0) begin
                chk("crc32_iso_hdlc", 64'(if_c32.crc_dat), 64'hCBF43926);
                chk("ecma182_w8",     if_e8.crc_dat,       64'h6C40DF5F0B497347);
                chk("sat_crc",        if_sat.crc_dat,      64'h62EC59E3F1A4F00A);
                chk("sat_cnt",        64'(if_sat.beat_cnt), 64'd3);
                @(negedge clk);
                chk("vld_one_cycle", 64'(if_we.crc_vld), 64'd0);
                @(posedge clk); #1;
            end
        end

        // Result stall between two back-to-back frames
        s_rdy = 1'b0;
        send_vec(vecs[0], 0, "stallA");
        s_vld = 1'b1; s_dat = vecs[1].d[0]; s_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_in_rdy", k),  64'(if_we.in_rdy),   64'd0);
            chk($sformatf("stall%0d_vld", k),     64'(if_we.crc_vld),  64'd1);
            chk($sformatf("stall%0d_crc", k),     if_we.crc_dat,       64'h62EC59E3F1A4F00A);
            chk($sformatf("stall%0d_cnt", k),     64'(if_we.beat_cnt), 64'd9);
            @(posedge clk); #1;
        end
        s_rdy = 1'b1;
        send_vec(vecs[1], 0, "stallB");

        // Soft clear mid-frame, with a last beat presented during the clear
        for (int j = 0; j < 4; j++) put_beat(vecs[0].d[j], 1'b0, vb);
        s_vld = 1'b1; s_dat = 8'h55; s_last = 1'b1; clr = 1'b1;
        @(negedge clk);
        chk("clr_in_rdy", 64'(if_we.in_rdy), 64'd0);
        @(posedge clk); #1;
        clr = 1'b0; s_vld = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("clr_no_vld", 64'(if_we.crc_vld), 64'd0);
        @(posedge clk); #1;
        send_vec(vecs[0], 0, "post_clr");

        // Reset pulse mid-frame
        for (int j = 0; j < 3; j++) put_beat(vecs[0].d[j], 1'b0, vb);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_vld", 64'(if_we.crc_vld), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_vld2", 64'(if_we.crc_vld), 64'd0);
        @(posedge clk); #1;
        send_vec(vecs[0], 0, "post_rst");

        // ECMA-182 one bit per beat, 72 beats, MSB of each byte first
        for (int b = 0; b < 72; b++) begin
            by = 8'(8'h31 + b / 8);
            e_vld = 1'b1; e_dat = by[7 - (b % 8)]; e_last = (b == 71);
            done = 1'b0;
            for (int k = 0; k < 40 && !done; k++) begin
                @(negedge clk);
                done = if_e1.in_rdy;
                @(posedge clk); #1;
            end
            if (!done) begin
                n_chk++; n_err++;
                $display("FAIL e1_accept_timeout: bit %0d still not accepted, want accepted within 40 cycles", b);
            end
        end
        e_vld = 1'b0; e_last = 1'b0;
        @(negedge clk);
        chk("ecma182_w1_vld", 64'(if_e1.crc_vld),  64'd1);
        chk("ecma182_w1_crc", if_e1.crc_dat,       64'h6C40DF5F0B497347);
        chk("ecma182_w1_cnt", 64'(if_e1.beat_cnt), 64'd72);
        chk("ecma182_w1_ok",  64'(if_e1.crc_ok),   64'd0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
